// File: rtl/verificar_senha_if.sv
// Keypad-to-verifier bundle: the one-cycle PIN packet in, lock/status outputs back.
interface verificar_senha_if #(
   parameter int MAX_ATTEMPTS = 3
);

   // digit1 is the newest key pressed, digit4 the oldest; 4'hE marks a blank position
   typedef struct packed {
      logic       status;
      logic [3:0] digit4;
      logic [3:0] digit3;
      logic [3:0] digit2;
      logic [3:0] digit1;
   } pinPac_t;

   pinPac_t                             pin_in;
   logic                                unlock;
   logic                                lockout;
   logic                                ok_pulse;
   logic                                fail_pulse;
   logic                                admin_mode;
   logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left;

   modport master (
      output pin_in,
      input  unlock, lockout, ok_pulse, fail_pulse, admin_mode, attempts_left
   );

   modport slave (
      input  pin_in,
      output unlock, lockout, ok_pulse, fail_pulse, admin_mode, attempts_left
   );

endinterface

// File: rtl/verificar_senha.sv
// PIN verifier: compares submitted PIN, drives unlock, counts failures, times lockout.
// Define PIN_CHANGE_EN to compile in the administrator (PIN change) mode.
module verificar_senha #(
   parameter logic [15:0] USER_PIN_RST         = 16'h1234,
   parameter logic [15:0] MASTER_PIN           = 16'h9999,
   parameter int          MAX_ATTEMPTS         = 3,
   parameter int          UNLOCK_CYCLES        = 100,
   parameter int          LOCKOUT_CYCLES       = 200,
   parameter int          ADMIN_TIMEOUT_CYCLES = 300
) (
   input logic               clk,
   input logic               rst,
   verificar_senha_if.slave  bus
);

   localparam int ATT_W   = $clog2(MAX_ATTEMPTS+1);
   localparam int MAX_A   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int MAX_CYC = (MAX_A > ADMIN_TIMEOUT_CYCLES) ? MAX_A : ADMIN_TIMEOUT_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] LOAD_UNLOCK  = CNT_W'(UNLOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_LOCKOUT = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_ADMIN   = CNT_W'(ADMIN_TIMEOUT_CYCLES - 1);
   localparam logic [ATT_W-1:0] ATT_MAX      = ATT_W'(MAX_ATTEMPTS);

`ifdef PIN_CHANGE_EN
   localparam bit ADMIN_EN = 1'b1;
`else
   localparam bit ADMIN_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      LOCKED  = 2'd0,
      OPEN    = 2'd1,
      BLOCKED = 2'd2,
      ADMIN   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ATT_W-1:0] att_q, att_d;
   logic             ok_q, ok_d;
   logic             fail_q, fail_d;
   logic             unlock_q, lockout_q;
   logic [15:0]      candidate;
   logic [15:0]      user_pin;
   logic             well_formed;
   logic             user_hit;
   logic             master_hit;

   assign candidate   = {bus.pin_in.digit4, bus.pin_in.digit3,
                         bus.pin_in.digit2, bus.pin_in.digit1};
   assign well_formed = (bus.pin_in.digit4 <= 4'd9) && (bus.pin_in.digit3 <= 4'd9) &&
                        (bus.pin_in.digit2 <= 4'd9) && (bus.pin_in.digit1 <= 4'd9);
   assign user_hit    = well_formed && (candidate == user_pin);
   assign master_hit  = well_formed && (candidate == MASTER_PIN);

`ifdef PIN_CHANGE_EN
   logic [15:0] user_pin_q, user_pin_d;
   logic        admin_q;

   // The changed PIN lives only until the next reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         user_pin_q <= USER_PIN_RST;
         admin_q    <= 1'b0;
      end else begin
         user_pin_q <= user_pin_d;
         admin_q    <= (state_d == ADMIN);
      end
   end

   assign user_pin       = user_pin_q;
   assign bus.admin_mode = admin_q;
`else
   assign user_pin       = USER_PIN_RST;
   assign bus.admin_mode = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOCKED;
         cnt_q     <= '0;
         att_q     <= ATT_MAX;
         ok_q      <= 1'b0;
         fail_q    <= 1'b0;
         unlock_q  <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         att_q     <= att_d;
         ok_q      <= ok_d;
         fail_q    <= fail_d;
         unlock_q  <= (state_d == OPEN);
         lockout_q <= (state_d == BLOCKED);
      end
   end

   // Each timed state is entered with its length minus one and leaves on the cycle the count is zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      att_d   = att_q;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
`ifdef PIN_CHANGE_EN
      user_pin_d = user_pin_q;
`endif
      case (state_q)
         LOCKED: begin
            if (bus.pin_in.status) begin
               if (ADMIN_EN && master_hit) begin
                  state_d = ADMIN;
                  cnt_d   = LOAD_ADMIN;
                  ok_d    = 1'b1;
                  att_d   = ATT_MAX;
               end else if (user_hit) begin
                  state_d = OPEN;
                  cnt_d   = LOAD_UNLOCK;
                  ok_d    = 1'b1;
                  att_d   = ATT_MAX;
               end else begin
                  fail_d = 1'b1;
                  att_d  = att_q - 1'b1;
                  if (att_q == ATT_W'(1)) begin
                     state_d = BLOCKED;
                     cnt_d   = LOAD_LOCKOUT;
                  end
               end
            end
         end
         OPEN: begin
            if (bus.pin_in.status || (cnt_q == '0)) begin
               state_d = LOCKED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BLOCKED: begin
            if (cnt_q == '0) begin
               state_d = LOCKED;
               att_d   = ATT_MAX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef PIN_CHANGE_EN
         ADMIN: begin
            if (bus.pin_in.status) begin
               state_d = LOCKED;
               cnt_d   = '0;
               if (well_formed) begin
                  user_pin_d = candidate;
                  ok_d       = 1'b1;
               end else begin
                  fail_d = 1'b1;
               end
            end else if (cnt_q == '0) begin
               state_d = LOCKED;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = LOCKED;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.unlock        = unlock_q;
   assign bus.lockout       = lockout_q;
   assign bus.ok_pulse      = ok_q;
   assign bus.fail_pulse    = fail_q;
   assign bus.attempts_left = att_q;

endmodule

// File: doc/verificar_senha.md
# verificar_senha

PIN verifier for the digital lock. Consumes the one-cycle `pinPac_t` packet produced by the keypad PIN-assembly stage. Compares the four submitted digits against a stored user PIN, then drives the door-unlock output, counts failed attempts and enforces a timed lockout. Optionally supports an administrator mode for changing the user PIN. Sits between keypad PIN assembly and the lock actuator/display logic.

## Interface
- `USER_PIN_RST`, 16'h1234: user PIN after reset, packed {digit4,digit3,digit2,digit1}; typing 1,2,3,4 then SEND yields 16'h1234.
- `MASTER_PIN`, 16'h9999: administrator PIN, same packing; used only with `PIN_CHANGE_EN`.
- `MAX_ATTEMPTS`, 3: consecutive failures before lockout, ≥1.
- `UNLOCK_CYCLES`, 100: cycles `unlock` stays high, ≥1.
- `LOCKOUT_CYCLES`, 200: cycles `lockout` stays high, ≥1.
- `ADMIN_TIMEOUT_CYCLES`, 300: idle cycles before admin mode is abandoned, ≥1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `pin_in`  in  pinPac_t: `status` is a one-cycle submit strobe; `digit1` is the newest digit, `digit4` the oldest; 4'hE means blank.
- `unlock`  out  1: door release.
- `lockout`  out  1: keypad blocked after too many failures.
- `ok_pulse`  out  1: one-cycle strobe for an accepted PIN.
- `fail_pulse`  out  1: one-cycle strobe for a rejected PIN.
- `attempts_left`  out  $clog2(MAX_ATTEMPTS+1): remaining attempts.
- `admin_mode`  out  1: high while in ADMIN; constant 0 without the macro.

## Operation
- Candidate PIN = {digit4,digit3,digit2,digit1}.
- A PIN is well-formed only if every digit ≤ 9. A blank or malformed PIN never matches and counts as a failure.
- States:
  - LOCKED: on `status`, compare the candidate.
    - Master match (macro only; takes priority over user match): go to ADMIN, pulse `ok_pulse`, set attempts to MAX.
    - User match: go to OPEN, pulse `ok_pulse`, set attempts to MAX.
    - Otherwise: pulse `fail_pulse` and decrement attempts. If attempts reach 0, go to BLOCKED.
  - OPEN: `unlock`=1 and the down-counter runs. The state ends on expiry, or on any `status`, which relocks immediately without comparing or pulsing. Next state: LOCKED.
  - BLOCKED: `lockout`=1 and `status` is ignored (no pulses, no count). On expiry go to LOCKED with attempts = MAX.
  - ADMIN (macro only):
    - Next `status` with a well-formed PIN: store it as the user PIN, pulse `ok_pulse`, go to LOCKED.
    - Next `status` with a malformed PIN: pulse `fail_pulse`, keep the stored PIN, go to LOCKED. Attempts are unaffected.
    - After ADMIN_TIMEOUT_CYCLES with no `status`: go to LOCKED, PIN unchanged.
- One shared down-counter, sized for the largest of the three cycle parameters, is loaded on every state entry.
- `status` is high for exactly one cycle per submission; no other qualification is needed.

## Timing
- All outputs are registered. `status` sampled at edge N sets the state, pulses and `attempts_left` at N+1.
- `unlock` is high for exactly UNLOCK_CYCLES consecutive cycles unless relocked early.
- `lockout` is high for exactly LOCKOUT_CYCLES consecutive cycles. `attempts_left` shows 0 throughout and MAX from the first LOCKED cycle.
- `ok_pulse` and `fail_pulse` are each exactly one cycle wide and never high together.
- A `status` in the same cycle as a timer expiry is handled by the state current in that cycle:
  - OPEN: relock.
  - BLOCKED: ignored.
  - ADMIN: processed as the admin PIN.
- Reset values: state LOCKED, `unlock`=0, `lockout`=0, `ok_pulse`=0, `fail_pulse`=0, `admin_mode`=0, `attempts_left`=MAX_ATTEMPTS, stored PIN=USER_PIN_RST, counter=0.
- Reset mid-operation aborts immediately. A changed PIN is not retained.

## Configuration
- `PIN_CHANGE_EN`:
  - Defined: ADMIN state, `MASTER_PIN` comparison and the writable user-PIN register are compiled in.
  - Undefined: the user PIN is the constant USER_PIN_RST, `MASTER_PIN` is ignored (a master submission is an ordinary compare), and `admin_mode` is tied 0.

## Test plan
- After reset, submit 1,2,3,4 -> `ok_pulse` one cycle at N+1, `unlock` high exactly 100 cycles, `attempts_left`=3.
- Submit 1,1,1,1 three times -> `fail_pulse` each time, `attempts_left` 2,1,0, `lockout` high 200 cycles. A correct PIN during lockout gives no pulse and no unlock. `attempts_left`=3 afterward.
- Submit "E,E,E,4" (only the 4 entered) -> `fail_pulse`, `attempts_left`=2.
- While OPEN, submit anything at cycle 10 -> `unlock` drops at cycle 11 with no pulse.
- With `PIN_CHANGE_EN`: submit 9,9,9,9 -> `admin_mode`=1. Submit 5,6,7,8 -> `ok_pulse`, LOCKED. Then 1,2,3,4 fails and 5,6,7,8 unlocks. Idle 300 cycles in ADMIN -> LOCKED with PIN unchanged.
- Assert `rst` mid-OPEN and mid-BLOCKED -> all outputs return to reset values at once, and the stored PIN reverts to 16'h1234.
